// File: rtl/parking_gate_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : parking_gate_controller_if
// Description : Keypad/sensor inputs and actuator/alarm outputs of the
//               parking-lot entry gate, grouped as a single bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface parking_gate_controller_if;
  logic [7:0] Pin;
  logic       enterPin;
  logic       Vehiculo;
  logic       Termino;
  logic       Cerrado;
  logic       Abierto;
  logic       Alarma;
  logic       Bloqueo;

  // Side that drives the sensors/keypad and watches the gate drivers
  modport master (
    output Pin, enterPin, Vehiculo, Termino,
    input  Cerrado, Abierto, Alarma, Bloqueo
  );

  // Gate controller side
  modport slave (
    input  Pin, enterPin, Vehiculo, Termino,
    output Cerrado, Abierto, Alarma, Bloqueo
  );
endinterface
`default_nettype wire

// File: rtl/parking_gate_controller.sv
`default_nettype none
// ============================================================================
// Module      : parking_gate_controller
// Description : Moore FSM for a single-lane parking entry gate. Validates a
//               strobed PIN, opens on a match, raises an alarm after
//               MAX_TRIES consecutive wrong PINs and blocks on tailgating.
// Revision    : 1.0 - initial release
// ============================================================================
module parking_gate_controller #(
  parameter logic [7:0] PIN_OK    = 8'h26,
  parameter int         MAX_TRIES = 3
) (
  input  wire logic                    Clk,
  input  wire logic                    Reset,
  parking_gate_controller_if.slave     gate
);

  // Attempt counter is 2 bits wide, so MAX_TRIES is limited to 1..3
  localparam logic [1:0] c_MAX_TRIES = 2'(MAX_TRIES);

  typedef enum logic [2:0] {
    ESPERA  = 3'd0,
    VALIDAR = 3'd1,
    ABIERTO = 3'd2,
    ALARMA  = 3'd3,
    BLOQUEO = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_intentos;
  logic [1:0] w_next_intentos;
  logic [1:0] w_intentos_inc;
  logic       w_pin_ok;
  logic       w_pin_bad;
  logic       w_cerrado;
  logic       w_abierto;
  logic       w_alarma;
  logic       w_bloqueo;

  assign w_pin_ok       = gate.enterPin && (gate.Pin == PIN_OK);
  assign w_pin_bad      = gate.enterPin && (gate.Pin != PIN_OK);
  assign w_intentos_inc = r_intentos + 2'd1;

  // State and wrong-attempt counter registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state    <= ESPERA;
      r_intentos <= 2'd0;
    end else begin
      r_state    <= w_next_state;
      r_intentos <= w_next_intentos;
    end
  end

  // Next-state and attempt-counter update
  always_comb begin
    w_next_state    = r_state;
    w_next_intentos = r_intentos;
    case (r_state)
      ESPERA: begin
        if (gate.Vehiculo) begin
          w_next_state = VALIDAR;
        end
      end
      VALIDAR: begin
        if (w_pin_ok) begin
          w_next_state    = ABIERTO;
          w_next_intentos = 2'd0;
        end else if (w_pin_bad) begin
          if (w_intentos_inc == c_MAX_TRIES) begin
            w_next_state    = ALARMA;
            w_next_intentos = 2'd0;
          end else begin
            w_next_intentos = w_intentos_inc;
          end
        end
      end
      ALARMA: begin
        // Counter was cleared on entry; only the correct PIN releases the gate
        if (w_pin_ok) begin
          w_next_state    = ABIERTO;
          w_next_intentos = 2'd0;
        end
      end
      ABIERTO: begin
        // A new vehicle arriving as the previous one clears is a tailgate
        if (gate.Vehiculo && gate.Termino) begin
          w_next_state = BLOQUEO;
        end else if (gate.Termino) begin
          w_next_state = ESPERA;
        end
      end
      BLOQUEO: begin
        if (w_pin_ok) begin
          w_next_state = ESPERA;
        end
      end
      default: begin
        // Unused encodings fall back to the safe closed/idle state
        w_next_state    = ESPERA;
        w_next_intentos = 2'd0;
      end
    endcase
  end

  // Moore output decode from the state register only
  always_comb begin
    w_cerrado = 1'b1;
    w_abierto = 1'b0;
    w_alarma  = 1'b0;
    w_bloqueo = 1'b0;
    case (r_state)
      ABIERTO: begin
        w_cerrado = 1'b0;
        w_abierto = 1'b1;
      end
      ALARMA: begin
        w_alarma  = 1'b1;
      end
      BLOQUEO: begin
        w_alarma  = 1'b1;
        w_bloqueo = 1'b1;
      end
      default: begin
        w_cerrado = 1'b1;
      end
    endcase
  end

  assign gate.Cerrado = w_cerrado;
  assign gate.Abierto = w_abierto;
  assign gate.Alarma  = w_alarma;
  assign gate.Bloqueo = w_bloqueo;

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_parking_gate_controller
// Description : Self-checking bench for parking_gate_controller. Directed
//               scenarios followed by random traffic, all compared against a
//               behavioural gate model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_gate_controller;

  localparam logic [7:0] c_PIN_OK    = 8'h26;
  localparam int         c_MAX_TRIES = 3;

  logic Clk;
  logic Reset;
  int   vectors;
  int   miscompares;

  parking_gate_controller_if gif ();

  parking_gate_controller #(
    .PIN_OK    (c_PIN_OK),
    .MAX_TRIES (c_MAX_TRIES)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .gate  (gif.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural model: the gate described as a set of conditions rather
  // than a state number
  bit m_open;      // gate physically open
  bit m_alarm;     // alarm sounding
  bit m_block;     // tailgate lockout
  bit m_waiting;   // vehicle detected, waiting for a PIN
  int m_wrong;     // consecutive wrong PINs while waiting

  task automatic model_step(input bit rn, input bit veh, input bit ter,
                            input bit ep, input logic [7:0] pin);
    bit good;
    bit bad;
    good = ep && (pin == c_PIN_OK);
    bad  = ep && (pin != c_PIN_OK);
    if (!rn) begin
      m_open = 0; m_alarm = 0; m_block = 0; m_waiting = 0; m_wrong = 0;
    end else if (m_block) begin
      if (good) begin m_block = 0; m_alarm = 0; end
    end else if (m_alarm) begin
      if (good) begin m_alarm = 0; m_open = 1; end
    end else if (m_open) begin
      if (veh && ter) begin m_open = 0; m_block = 1; m_alarm = 1; end
      else if (ter)   begin m_open = 0; end
    end else if (m_waiting) begin
      if (good) begin
        m_waiting = 0; m_open = 1; m_wrong = 0;
      end else if (bad) begin
        m_wrong = m_wrong + 1;
        if (m_wrong >= c_MAX_TRIES) begin
          m_waiting = 0; m_alarm = 1; m_wrong = 0;
        end
      end
    end else if (veh) begin
      m_waiting = 1;
    end
  endtask

  task automatic check(input string tag);
    logic [3:0] obs;
    logic [3:0] exp;
    obs = {gif.Cerrado, gif.Abierto, gif.Alarma, gif.Bloqueo};
    exp = {~m_open, m_open, m_alarm, m_block};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed Cerrado/Abierto/Alarma/Bloqueo=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample 1ns after the rising edge
  task automatic step(input bit rn, input bit veh, input bit ter,
                      input bit ep, input logic [7:0] pin, input string tag);
    @(negedge Clk);
    Reset        = rn;
    gif.Vehiculo = veh;
    gif.Termino  = ter;
    gif.enterPin = ep;
    gif.Pin      = pin;
    @(posedge Clk);
    model_step(rn, veh, ter, ep, pin);
    #1;
    check(tag);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    Reset        = 1'b0;
    gif.Vehiculo = 1'b0;
    gif.Termino  = 1'b0;
    gif.enterPin = 1'b0;
    gif.Pin      = 8'h00;

    // 1. reset
    step(0, 0, 0, 0, 8'h00, "reset0");
    step(0, 0, 0, 0, 8'h00, "reset1");
    step(1, 0, 0, 0, 8'h00, "idle");

    // 2. correct PIN opens, vehicle passes, gate closes
    step(1, 1, 0, 0, 8'h00, "t2_detect");
    step(1, 1, 0, 1, 8'h26, "t2_open");
    step(1, 1, 0, 0, 8'h00, "t2_hold_open");
    step(1, 0, 1, 0, 8'h00, "t2_close");

    // 3. two wrong PINs then correct
    step(1, 1, 0, 0, 8'h00, "t3_detect");
    step(1, 1, 0, 1, 8'h11, "t3_wrong1");
    step(1, 0, 0, 1, 8'h11, "t3_wrong2");
    step(1, 0, 0, 1, 8'h26, "t3_open");
    step(1, 0, 1, 0, 8'h00, "t3_close");

    // 4. three wrong PINs raise the alarm (counter must have restarted)
    step(1, 1, 0, 0, 8'h00, "t4_detect");
    step(1, 1, 0, 1, 8'h00, "t4_wrong1");
    step(1, 1, 0, 1, 8'hFF, "t4_wrong2");
    step(1, 1, 0, 1, 8'h27, "t4_alarm");
    step(1, 1, 0, 1, 8'h11, "t4_alarm_hold");
    step(1, 1, 0, 1, 8'h26, "t4_open");

    // 5. tailgate from open, wrong PIN ignored, correct PIN releases
    step(1, 1, 1, 0, 8'h00, "t5_block");
    step(1, 0, 0, 1, 8'h55, "t5_block_hold");
    step(1, 0, 0, 1, 8'h26, "t5_release");

    // 6. reset from BLOQUEO and from ALARMA; PIN strobes in idle
    step(1, 1, 0, 0, 8'h00, "t6_detect");
    step(1, 1, 0, 1, 8'h26, "t6_open");
    step(1, 1, 1, 0, 8'h00, "t6_block");
    step(0, 1, 1, 1, 8'h26, "t6_reset_block");
    step(1, 1, 0, 0, 8'h00, "t6_detect2");
    step(1, 1, 0, 1, 8'h01, "t6_wrong1");
    step(1, 1, 0, 1, 8'h02, "t6_wrong2");
    step(1, 1, 0, 1, 8'h03, "t6_alarm");
    step(0, 1, 0, 1, 8'h26, "t6_reset_alarm");
    step(1, 0, 0, 1, 8'h26, "t6_idle_pin_ok");
    step(1, 0, 0, 1, 8'h99, "t6_idle_pin_bad");
    step(1, 0, 1, 0, 8'h00, "t6_idle_termino");

    // Random traffic, biased towards the correct PIN and frequent sensors
    for (int i = 0; i < 800; i++) begin
      bit         rn;
      bit         veh;
      bit         ter;
      bit         ep;
      logic [7:0] pin;
      rn  = ($urandom_range(0, 59) != 0);
      veh = $urandom_range(0, 1) == 1;
      ter = $urandom_range(0, 2) == 0;
      ep  = $urandom_range(0, 2) == 0;
      pin = ($urandom_range(0, 3) == 0) ? c_PIN_OK : 8'($urandom);
      step(rn, veh, ter, ep, pin, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
